fpio_fifo_wr_arb: RTL and testbench
===================================

# fpio_fifo_wr_arb

Round-robin write arbiter that shares the input side of one `fpio_fifo` between `NUM_REQ` producers. Each producer uses a valid/ack word handshake. The arbiter serialises granted words onto the FIFO `data_en`/`data_ack`/`avail` port and never has more than one word outstanding. It sits directly in front of `fpio_fifo.in`, and the FIFO's clock and reset are shared with it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers, 2..16.
- `DATA_WIDTH`, 32: word width; must match the FIFO.
- `FIFO_BITS`, 4: FIFO depth exponent; `avail` is `FIFO_BITS+1` bits wide.
- `MAX_BURST`, 4: maximum consecutive words granted to one producer while others wait, 1..255.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, `NUM_REQ`: producer i has a word; held high with stable data until `req_ack[i]`.
- `req_data`, input, `NUM_REQ*DATA_WIDTH`: producer i word at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ack`, output, `NUM_REQ`: one-cycle pulse; the word is written.
- `fifo_data_en`, output, 1: FIFO write strobe (connects to `in.data_en`).
- `fifo_data`, output, `DATA_WIDTH`: FIFO write word (connects to `in.data`).
- `fifo_data_ack`, input, 1: FIFO ack (`in.data_ack`); arrives the cycle after `data_en`.
- `fifo_avail`, input, `FIFO_BITS+1`: free slots (`in.avail`).
- `grant_id`, output, `max(1,$clog2(NUM_REQ))`: index of the current or last granted producer.
- `busy`, output, 1: high in ISSUE and WAIT_ACK.

## Operation
- FSM states: IDLE, ISSUE, WAIT_ACK.
- **IDLE to ISSUE:** taken when `fifo_avail != 0` and any `req_valid` is set. The grant is decided and `fifo_data <= req_data[grant]` is registered.
- **ISSUE:** `fifo_data_en = 1` for exactly one cycle, then unconditional move to WAIT_ACK.
- **WAIT_ACK:** `fifo_data_en = 0`.
  - When `fifo_data_ack = 1`: `req_ack[grant_id] = 1` combinationally in that cycle, then move to IDLE.
  - Without ack, the FSM stays in WAIT_ACK indefinitely. There is no timeout.
- **Grant rule:**
  - Stick with `grant_id` if `req_valid[grant_id]` is set and `burst_cnt < MAX_BURST`; then `burst_cnt++`.
  - Otherwise rotate: search from `grant_id+1` modulo `NUM_REQ` upward, take the first valid producer, and set `burst_cnt = 1`.
  - The rotate search includes `grant_id` itself last, so a lone producer is re-granted with `burst_cnt` reset to 1.
- `grant_id` reset value is `NUM_REQ-1`, so the first search starts at producer 0.
- `burst_cnt` is 8 bits and saturates; it is only compared against `MAX_BURST`.
- **Flow control:** `fifo_avail` is sampled only in IDLE.
  - The FIFO count updates two edges after `data_en`, and IDLE is reached no earlier than that, so `avail` is current.
  - With one word in flight, overflow is impossible.
- `req_valid` changes in ISSUE/WAIT_ACK are ignored. `fifo_data` is captured in the grant cycle.
- A producer that drops valid without an ack loses its grant priority at the next IDLE. No word is written for it unless the drop happened after the grant.

## Timing
- Reset values: `req_ack = 0`, `fifo_data_en = 0`, `fifo_data = 0`, `grant_id = NUM_REQ-1`, `busy = 0`, `burst_cnt = 0`, state = IDLE.
- Latency with the FIFO not full:
  - `req_valid` rises in cycle N (IDLE), giving ISSUE in N+1, WAIT_ACK with `req_ack` in N+2, IDLE in N+3.
  - Throughput is 1 word per 3 cycles.
  - A back-to-back producer holding valid high after its ack gets its next `data_en` at N+4.
- **FIFO full** (`avail == 0`): stay in IDLE with no `data_en`. Issue resumes the cycle after `avail` becomes nonzero is seen in IDLE.
- **Simultaneous requests:** only one grant per IDLE cycle; the others stay pending with `req_ack` low.
- **Reset asserted mid-operation:** all state clears asynchronously and no `req_ack` is emitted. Whether a word issued in ISSUE is written is undefined; the FIFO is reset too.
- `req_ack` is never asserted outside WAIT_ACK, and never for more than one bit or more than one cycle per word.

## Test plan
- **Single producer 0, 3 words A,B,C:** FIFO sees `data_en` at cycles 1, 4, 7 with data A, B, C; `req_ack[0]` at 2, 5, 8; `grant_id = 0` throughout.
- **All 4 producers continuously valid, MAX_BURST=2:** grant order is 0,0,1,1,2,2,3,3,0,0; each `req_ack` carries the matching data; at most one `data_en` outstanding.
- **Wrap:** producers 3 and 0 valid, MAX_BURST=1, starting after `grant_id = 3`. Order is 0,3,0,3.
- **FIFO_BITS=2 with the consumer stalled:** exactly 4 words are accepted. `avail = 0` holds the arbiter in IDLE with `fifo_data_en` low. Popping 1 word lets exactly 1 more issue.
- **Producer 1 drops valid while producer 2 is pending** (grant held by 1, `burst_cnt = 1`, MAX_BURST=4): the next grant goes to 2 with `burst_cnt = 1`.
- **`rstn` pulsed low during ISSUE:** the same cycle shows `fifo_data_en = 0`, `busy = 0`, `grant_id = NUM_REQ-1`, no `req_ack`. After release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/fpio_fifo_wr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpio_fifo_wr_arb_if
//  Description : Producer-side and FIFO-side signals of the write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpio_fifo_wr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_BITS  = 4
);
    localparam int c_GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          fifo_data_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          fifo_data_ack;
    logic [FIFO_BITS:0]            fifo_avail;
    logic [c_GRANT_W-1:0]          grant_id;
    logic                          busy;

    // The arbiter is the slave; producers plus FIFO form the master side.
    modport slave (
        input  req_valid, req_data, fifo_data_ack, fifo_avail,
        output req_ack, fifo_data_en, fifo_data, grant_id, busy
    );

    modport master (
        output req_valid, req_data, fifo_data_ack, fifo_avail,
        input  req_ack, fifo_data_en, fifo_data, grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/fpio_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fpio_fifo_wr_arb
//  Description : Round-robin, burst-limited write arbiter feeding one
//                fpio_fifo input port, one word in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpio_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_BITS  = 4,
    parameter int MAX_BURST  = 4
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    fpio_fifo_wr_arb_if.slave bus
);
    localparam int c_GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [c_GRANT_W:0] c_NUM_REQ   = (c_GRANT_W+1)'(NUM_REQ);
    localparam logic [7:0]         c_MAX_BURST = 8'(MAX_BURST);
    localparam logic [c_GRANT_W-1:0] c_LAST_ID = c_GRANT_W'(NUM_REQ - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_WAIT_ACK = 2'd2;

    logic [1:0]            r_state;
    logic [c_GRANT_W-1:0]  r_grant_id;
    logic [7:0]            r_burst_cnt;
    logic                  r_fifo_data_en;
    logic [DATA_WIDTH-1:0] r_fifo_data;
    logic                  r_busy;

    logic                  w_stick;
    logic                  w_rot_found;
    logic [c_GRANT_W-1:0]  w_rot_id;
    logic [c_GRANT_W:0]    w_sum;
    logic [c_GRANT_W-1:0]  w_next_id;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [NUM_REQ-1:0]    w_req_ack;

    // burst_cnt == 0 only after reset: no producer owns the grant yet.
    assign w_stick = bus.req_valid[r_grant_id] && (r_burst_cnt != 8'd0) &&
                     (r_burst_cnt < c_MAX_BURST);

    // Search starts one past the current owner and visits it last.
    always_comb begin
        w_rot_found = 1'b0;
        w_rot_id    = r_grant_id;
        w_sum       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_grant_id} + (c_GRANT_W+1)'(k);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (!w_rot_found && bus.req_valid[w_sum[c_GRANT_W-1:0]]) begin
                w_rot_found = 1'b1;
                w_rot_id    = w_sum[c_GRANT_W-1:0];
            end
        end
    end

    assign w_next_id = w_stick ? r_grant_id : w_rot_id;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_next_id == c_GRANT_W'(i)) begin
                w_sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= c_IDLE;
            r_grant_id     <= c_LAST_ID;
            r_burst_cnt    <= 8'd0;
            r_fifo_data_en <= 1'b0;
            r_fifo_data    <= '0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if ((bus.fifo_avail != '0) && w_rot_found) begin
                        r_state        <= c_ISSUE;
                        r_fifo_data_en <= 1'b1;
                        r_busy         <= 1'b1;
                        r_grant_id     <= w_next_id;
                        r_fifo_data    <= w_sel_data;
                        if (!w_stick) begin
                            r_burst_cnt <= 8'd1;
                        end else if (r_burst_cnt != 8'hFF) begin
                            r_burst_cnt <= r_burst_cnt + 8'd1;
                        end
                    end
                end
                c_ISSUE: begin
                    r_state        <= c_WAIT_ACK;
                    r_fifo_data_en <= 1'b0;
                end
                c_WAIT_ACK: begin
                    if (bus.fifo_data_ack) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= c_IDLE;
                    r_fifo_data_en <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    // Producer ack follows the FIFO ack in the same cycle.
    always_comb begin
        w_req_ack = '0;
        if ((r_state == c_WAIT_ACK) && bus.fifo_data_ack) begin
            w_req_ack[r_grant_id] = 1'b1;
        end
    end

    assign bus.req_ack      = w_req_ack;
    assign bus.fifo_data_en = r_fifo_data_en;
    assign bus.fifo_data    = r_fifo_data;
    assign bus.grant_id     = r_grant_id;
    assign bus.busy         = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_fpio_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpio_fifo_wr_arb
//  Description : Self-checking bench: cycle vectors, FIFO model, scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpio_fifo_wr_arb;
    localparam int NR    = 4;
    localparam int DW    = 32;
    localparam int FB    = 2;
    localparam int MB    = 2;
    localparam int DEPTH = 1 << FB;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fpio_fifo_wr_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_BITS(FB)) bus ();

    fpio_fifo_wr_arb #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_BITS(FB), .MAX_BURST(MB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          exp_en;
        logic [NR-1:0] exp_ack;
        logic [1:0]    exp_gid;
        logic          exp_busy;
    } vec_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    int            pass_cnt = 0;
    int            total_cnt = 0;
    logic          use_table;
    logic          tbl_valid;
    logic [DW-1:0] tbl_data;
    logic [NR-1:0] en;
    int            quota   [NR];
    int            ack_cnt [NR];
    int            exp_seq [NR];
    int            fifo_cnt;
    int            wr_total;
    int            wr_base;
    logic          fifo_ack;
    logic          pop_en;
    logic          pop_once;
    logic          en_s;
    logic          pop_s;
    logic          outstanding;
    logic          seen;
    int            n;
    exp_t          exp_q[$];
    int            rd_idx;
    vec_t          tbl[11];

    function automatic logic [DW-1:0] prod_word(input int i, input int k);
        return {8'(8'hA0 + i), 24'(k)};
    endfunction

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i] = use_table ? ((i == 0) && tbl_valid)
                                         : (en[i] && (ack_cnt[i] < quota[i]));
            bus.req_data[i*DW +: DW] = use_table ? tbl_data : prod_word(i, ack_cnt[i]);
        end
    end

    assign bus.fifo_avail    = (FB+1)'(DEPTH - fifo_cnt);
    assign bus.fifo_data_ack = fifo_ack;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_exp(input int id, input bit adv);
        exp_t e;
        e.id   = id;
        e.data = prod_word(id, exp_seq[id]);
        exp_q.push_back(e);
        if (adv) exp_seq[id]++;
    endtask

    // Negedge half of a cycle: scoreboard monitor and FIFO input sampling.
    task automatic tick_neg();
        @(negedge clk);
        if (bus.fifo_data_en) begin
            chk("single_outstanding", outstanding, 0);
            if (rd_idx < exp_q.size()) begin
                chk("grant_id_at_issue", bus.grant_id, exp_q[rd_idx].id);
                chk("fifo_data", bus.fifo_data, exp_q[rd_idx].data);
            end else begin
                chk("unexpected_issue", rd_idx, exp_q.size());
            end
            rd_idx++;
            outstanding = 1'b1;
        end
        if (bus.req_ack != '0) begin
            chk("req_ack_onehot", bus.req_ack, NR'(1) << bus.grant_id);
            chk("ack_after_issue", outstanding, 1);
            outstanding = 1'b0;
            if (!use_table) begin
                for (int i = 0; i < NR; i++) if (bus.req_ack[i]) ack_cnt[i]++;
            end
        end
        en_s  = bus.fifo_data_en;
        pop_s = (pop_en || pop_once) && (fifo_cnt > 0);
    endtask

    task automatic tick_pos();
        @(posedge clk);
        #1;
        fifo_ack = en_s;
        if (en_s) begin
            wr_total++;
            if (fifo_cnt == DEPTH) chk("no_overflow", fifo_cnt, DEPTH - 1);
            else fifo_cnt++;
        end
        if (pop_s) fifo_cnt--;
        pop_once = 1'b0;
    endtask

    task automatic tick();
        tick_neg();
        tick_pos();
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (((rd_idx < exp_q.size()) || bus.busy) && (k < budget)) begin
            tick();
            k++;
        end
        chk({name, "_all_issued"}, rd_idx, exp_q.size());
        chk({name, "_idle"}, bus.busy, 0);
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        fifo_cnt    = 0;
        fifo_ack    = 1'b0;
        outstanding = 1'b0;
        en_s        = 1'b0;
        pop_s       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic set_vec(input int r, input logic v, input logic [DW-1:0] d, input logic e,
                           input logic [NR-1:0] a, input logic [1:0] g, input logic b);
        tbl[r].valid = v;  tbl[r].data = d;  tbl[r].exp_en = e;
        tbl[r].exp_ack = a; tbl[r].exp_gid = g; tbl[r].exp_busy = b;
    endtask

    initial begin
        // Single producer 0, words A, B, C: data_en at 1,4,7 and ack at 2,5,8.
        set_vec(0,  1, 32'hAAAA_0001, 0, 4'b0000, 2'd3, 0);
        set_vec(1,  1, 32'hAAAA_0001, 1, 4'b0000, 2'd0, 1);
        set_vec(2,  1, 32'hAAAA_0001, 0, 4'b0001, 2'd0, 1);
        set_vec(3,  1, 32'hBBBB_0002, 0, 4'b0000, 2'd0, 0);
        set_vec(4,  1, 32'hBBBB_0002, 1, 4'b0000, 2'd0, 1);
        set_vec(5,  1, 32'hBBBB_0002, 0, 4'b0001, 2'd0, 1);
        set_vec(6,  1, 32'hCCCC_0003, 0, 4'b0000, 2'd0, 0);
        set_vec(7,  1, 32'hCCCC_0003, 1, 4'b0000, 2'd0, 1);
        set_vec(8,  1, 32'hCCCC_0003, 0, 4'b0001, 2'd0, 1);
        set_vec(9,  0, 32'hCCCC_0003, 0, 4'b0000, 2'd0, 0);
        set_vec(10, 0, 32'hCCCC_0003, 0, 4'b0000, 2'd0, 0);

        rstn = 1'b0; use_table = 1'b1; tbl_valid = 1'b0; tbl_data = '0;
        en = '0; fifo_cnt = 0; wr_total = 0; fifo_ack = 1'b0; pop_en = 1'b1;
        pop_once = 1'b0; en_s = 1'b0; pop_s = 1'b0; outstanding = 1'b0; rd_idx = 0;
        for (int i = 0; i < NR; i++) begin
            quota[i] = 0; ack_cnt[i] = 0; exp_seq[i] = 0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data_en", bus.fifo_data_en, 0);
        chk("rst_fifo_data", bus.fifo_data, 0);
        chk("rst_grant_id", bus.grant_id, NR - 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ack", bus.req_ack, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        for (int r = 0; r < 11; r++) begin
            if (tbl[r].exp_en) exp_q.push_back('{id: 0, data: tbl[r].data});
        end
        for (int r = 0; r < 11; r++) begin
            tbl_valid = tbl[r].valid;
            tbl_data  = tbl[r].data;
            tick_neg();
            chk($sformatf("vec%0d_data_en", r), bus.fifo_data_en, tbl[r].exp_en);
            chk($sformatf("vec%0d_req_ack", r), bus.req_ack, tbl[r].exp_ack);
            chk($sformatf("vec%0d_grant_id", r), bus.grant_id, tbl[r].exp_gid);
            chk($sformatf("vec%0d_busy", r), bus.busy, tbl[r].exp_busy);
            tick_pos();
        end
        use_table = 1'b0;

        // All producers valid, MAX_BURST=2.
        do_reset();
        for (int i = 0; i < NR; i++) quota[i] += 3;
        en = '1;
        for (int i = 0; i < NR; i++) begin
            push_exp(i, 1); push_exp(i, 1);
        end
        for (int i = 0; i < NR; i++) push_exp(i, 1);
        wait_done(100, "all_valid");

        // Wrap: producer 3 owns the grant, then 0 joins.
        en = '0;
        do_reset();
        en[3] = 1'b1; quota[3] += 2;
        push_exp(3, 1); push_exp(3, 1);
        wait_done(30, "wrap_pre");
        en[0] = 1'b1; quota[0] += 3; quota[3] += 2;
        push_exp(0, 1); push_exp(0, 1); push_exp(3, 1); push_exp(3, 1); push_exp(0, 1);
        wait_done(60, "wrap");

        // FIFO full: stalled consumer, depth 4.
        en = '0;
        do_reset();
        pop_en = 1'b0; wr_base = wr_total;
        en[0] = 1'b1; quota[0] += 6;
        for (int i = 0; i < 6; i++) push_exp(0, 1);
        repeat (30) tick();
        chk("full_count", fifo_cnt, DEPTH);
        chk("full_written", wr_total - wr_base, 4);
        chk("full_busy", bus.busy, 0);
        for (int i = 0; i < 5; i++) begin
            tick_neg();
            chk("full_no_issue", bus.fifo_data_en, 0);
            tick_pos();
        end
        pop_once = 1'b1;
        repeat (15) tick();
        chk("pop1_written", wr_total - wr_base, 5);
        chk("pop1_count", fifo_cnt, DEPTH);
        pop_en = 1'b1;
        wait_done(60, "full_drain");

        // Producer 1 drops valid after its first ack; 2 and 3 pending.
        en = '0;
        do_reset();
        en[1] = 1'b1; en[2] = 1'b1; en[3] = 1'b1;
        quota[1] += 3; quota[2] += 2; quota[3] += 1;
        push_exp(1, 1); push_exp(2, 1); push_exp(2, 1); push_exp(3, 1);
        seen = 1'b0; n = 0;
        while (!seen && (n < 30)) begin
            tick_neg();
            if (bus.req_ack[1]) begin
                seen  = 1'b1;
                en[1] = 1'b0;
            end
            tick_pos();
            n++;
        end
        chk("drop_ack1_seen", seen, 1);
        wait_done(60, "drop");
        chk("drop_last_grant", bus.grant_id, 3);
        en[1] = 1'b1;
        push_exp(1, 1); push_exp(1, 1);
        wait_done(30, "drop_resume");

        // Reset pulsed during ISSUE.
        en = '0;
        do_reset();
        en[2] = 1'b1; en[3] = 1'b1; quota[2] += 1; quota[3] += 1;
        push_exp(2, 0);
        seen = 1'b0; n = 0;
        while (!seen && (n < 20)) begin
            tick_neg();
            if (bus.fifo_data_en) seen = 1'b1;
            else tick_pos();
            n++;
        end
        chk("rst_mid_issue_seen", seen, 1);
        #1 rstn = 1'b0;
        #1;
        chk("rst_mid_data_en", bus.fifo_data_en, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_grant_id", bus.grant_id, NR - 1);
        chk("rst_mid_req_ack", bus.req_ack, 0);
        fifo_cnt = 0; fifo_ack = 1'b0; outstanding = 1'b0; en_s = 1'b0; pop_s = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        push_exp(2, 1); push_exp(3, 1);
        wait_done(40, "rst_mid_after");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
